// File: rtl/vblank_scheduler_pkg.sv
// Shared types for the per-frame game-logic scheduler: FSM states, task count and task indices.
package vblank_scheduler_pkg;

   localparam int unsigned N_TASKS_DEF = 4;

   localparam int unsigned TASK_TOM   = 0;
   localparam int unsigned TASK_JERRY = 1;
   localparam int unsigned TASK_COLL  = 2;
   localparam int unsigned TASK_SCORE = 3;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StWait,
      StCommit,
      StDone,
      StAbort
   } vbs_state_e;

endpackage

// File: rtl/vblank_edge_det.sv
// Rising-edge detector for vblnk. The history register resets high so a frame already
// in blanking at reset release never produces a rise.
module vblank_edge_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_vblnk,
   output logic o_rise
);

   logic r_vblnk_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_vblnk_q <= 1'b1;
      else       r_vblnk_q <= i_vblnk;
   end

   assign o_rise = i_vblnk & ~r_vblnk_q;

endmodule

// File: rtl/vblank_scheduler.sv
// Runs the game-logic tasks one at a time inside vertical blanking, then commits the frame.
// Optional per-task WAIT timeout is enabled with `define VBS_TIMEOUT_EN.
module vblank_scheduler
   import vblank_scheduler_pkg::*;
#(
   parameter int unsigned N_TASKS        = N_TASKS_DEF,
   parameter int unsigned FRAME_W        = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_vblnk,
   input  logic               i_enable,
   input  logic [N_TASKS-1:0] i_task_done,
   input  logic               i_clr_overrun,
   output logic [N_TASKS-1:0] o_task_start,
   output logic [N_TASKS-1:0] o_task_active,
   output logic               o_commit,
   output logic               o_abort,
   output logic               o_busy,
   output logic [FRAME_W-1:0] o_frame_cnt,
   output logic               o_overrun,
   output logic [N_TASKS-1:0] o_timeout_err
);

   localparam int unsigned IDX_W = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TASKS - 1);

   vbs_state_e         r_state, w_state_d;
   logic [IDX_W-1:0]   r_idx, w_idx_d;
   logic [FRAME_W-1:0] r_frame_cnt;
   logic               r_overrun;
   logic               w_rise;
   logic               w_done;
   logic               w_set_overrun;
   logic [N_TASKS-1:0] w_idx_onehot;
   logic [N_TASKS-1:0] w_set_timeout;

   vblank_edge_det u_edge_det (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_vblnk(i_vblnk),
      .o_rise (w_rise)
   );

   assign w_done       = i_task_done[r_idx];
   assign w_idx_onehot = N_TASKS'(1) << r_idx;

`ifdef VBS_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0]   r_wait_cnt;
   logic [N_TASKS-1:0] r_timeout_err;
   logic               w_timeout;

   assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counts from the START cycle so the abort lands TIMEOUT_CYCLES after task_start.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                       r_wait_cnt <= '0;
      else if (w_state_d == StStart)                   r_wait_cnt <= '0;
      else if (r_state == StStart || r_state == StWait) r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_timeout_err <= '0;
      else       r_timeout_err <= w_set_timeout | (i_clr_overrun ? '0 : r_timeout_err);
   end

   assign o_timeout_err = r_timeout_err;
`else
   assign o_timeout_err = '0;
`endif

   always_comb begin
      w_state_d     = r_state;
      w_idx_d       = r_idx;
      w_set_overrun = 1'b0;
      w_set_timeout = '0;
      unique case (r_state)
         StIdle: begin
            if (w_rise && i_enable) begin
               w_idx_d   = '0;
               w_state_d = StStart;
            end
         end
         StStart: w_state_d = StWait;
         StWait: begin
            // End of blanking beats both done and timeout.
            if (!i_vblnk) begin
               w_set_overrun = 1'b1;
               w_state_d     = StAbort;
            end else if (w_done) begin
               if (r_idx == LAST_IDX) begin
                  w_state_d = StCommit;
               end else begin
                  w_idx_d   = r_idx + 1'b1;
                  w_state_d = StStart;
               end
            end
`ifdef VBS_TIMEOUT_EN
            else if (w_timeout) begin
               w_set_timeout = w_idx_onehot;
               w_state_d     = StAbort;
            end
`endif
         end
         StCommit: w_state_d = StDone;
         StDone:   if (!i_vblnk) w_state_d = StIdle;
         StAbort:  w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_d;
         r_idx   <= w_idx_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                   r_frame_cnt <= '0;
      else if (r_state == StCommit) r_frame_cnt <= r_frame_cnt + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)              r_overrun <= 1'b0;
      else if (w_set_overrun) r_overrun <= 1'b1;
      else if (i_clr_overrun) r_overrun <= 1'b0;
   end

   // Outputs decode straight from registered state, so pulses align with state entry.
   assign o_task_start  = (r_state == StStart) ? w_idx_onehot : '0;
   assign o_task_active = (r_state == StWait) ? w_idx_onehot : '0;
   assign o_commit      = (r_state == StCommit);
   assign o_abort       = (r_state == StAbort);
   assign o_busy        = (r_state != StIdle);
   assign o_frame_cnt   = r_frame_cnt;
   assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Directed bench for vblank_scheduler (4 tasks, 4-bit frame counter, 16-cycle timeout).
module tb_vblank_scheduler;

   localparam int unsigned NT = 4;
   localparam int unsigned FW = 4;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          vblnk;
   logic          enable;
   logic [NT-1:0] task_done;
   logic          clr_overrun;
   logic [NT-1:0] task_start;
   logic [NT-1:0] task_active;
   logic          commit;
   logic          abort;
   logic          busy;
   logic [FW-1:0] frame_cnt;
   logic          overrun;
   logic [NT-1:0] timeout_err;

   int            n_vec = 0;
   int            n_miss = 0;
   int            n_commit = 0;
   logic [FW-1:0] exp_frames;

   vblank_scheduler #(
      .N_TASKS       (NT),
      .FRAME_W       (FW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_vblnk      (vblnk),
      .i_enable     (enable),
      .i_task_done  (task_done),
      .i_clr_overrun(clr_overrun),
      .o_task_start (task_start),
      .o_task_active(task_active),
      .o_commit     (commit),
      .o_abort      (abort),
      .o_busy       (busy),
      .o_frame_cnt  (frame_cnt),
      .o_overrun    (overrun),
      .o_timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (commit) n_commit <= n_commit + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Assumes the DUT is in START for task 'first'; finishes every task through COMMIT.
   task automatic serve(input int first);
      for (int i = first; i < NT; i++) begin
         tick;
         task_done    = '0;
         task_done[i] = 1'b1;
         tick;
         task_done = '0;
      end
   endtask

   task automatic quick_frame;
      vblnk = 1'b1;
      tick;
      serve(0);
      tick;
      vblnk = 1'b0;
      tick;
      exp_frames = exp_frames + 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; vblnk = 1'b0; enable = 1'b0; task_done = '0; clr_overrun = 1'b0;
      exp_frames = '0;
      repeat (2) tick;
      n_vec++;
      if ({task_start, task_active, commit, abort, busy, overrun, timeout_err} !== '0) begin
         n_miss++;
         $display("FAIL reset_outputs: got start=%b active=%b c=%b a=%b busy=%b ovr=%b to=%b, want 0",
                  task_start, task_active, commit, abort, busy, overrun, timeout_err);
      end
      n_vec++;
      if (frame_cnt !== 4'd0) begin
         n_miss++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
      end
      rst = 1'b0; enable = 1'b1;
      tick;
   endtask

   task automatic test_nominal;
      logic [NT-1:0] exp;
      int            c0;
      c0 = n_commit;
      vblnk = 1'b1;
      tick;
      for (int i = 0; i < NT; i++) begin
         exp = '0; exp[i] = 1'b1;
         n_vec++;
         if (task_start !== exp) begin
            n_miss++; $display("FAIL nom_start%0d: got %b want %b", i, task_start, exp);
         end
         tick;
         n_vec++;
         if (task_active !== exp || task_start !== '0) begin
            n_miss++;
            $display("FAIL nom_active%0d: got act=%b st=%b want act=%b st=0", i, task_active,
                     task_start, exp);
         end
         repeat (8) tick;
         task_done[i] = 1'b1;
         tick;
         task_done = '0;
      end
      n_vec++;
      if (commit !== 1'b1) begin
         n_miss++; $display("FAIL nom_commit: got %b want 1", commit);
      end
      tick;
      exp_frames = exp_frames + 1'b1;
      n_vec++;
      if (commit !== 1'b0 || frame_cnt !== exp_frames || overrun !== 1'b0) begin
         n_miss++;
         $display("FAIL nom_after_commit: got c=%b cnt=%0d ovr=%b want c=0 cnt=%0d ovr=0",
                  commit, frame_cnt, overrun, exp_frames);
      end
      repeat (30) tick;
      n_vec++;
      if (busy !== 1'b1) begin
         n_miss++; $display("FAIL nom_busy_in_blank: got %b want 1", busy);
      end
      vblnk = 1'b0;
      tick;
      n_vec++;
      if (busy !== 1'b0 || n_commit - c0 != 1) begin
         n_miss++;
         $display("FAIL nom_end: got busy=%b commits=%0d want busy=0 commits=1", busy,
                  n_commit - c0);
      end
   endtask

   task automatic test_overrun;
      int c0;
      c0 = n_commit;
      vblnk = 1'b1;
      tick;
      for (int i = 0; i < 2; i++) begin
         tick; task_done[i] = 1'b1; tick; task_done = '0;
      end
      repeat (4) tick;
      vblnk = 1'b0;
      tick;
      n_vec++;
      if (abort !== 1'b1 || commit !== 1'b0 || overrun !== 1'b1) begin
         n_miss++;
         $display("FAIL ovr_abort: got a=%b c=%b ovr=%b want a=1 c=0 ovr=1", abort, commit,
                  overrun);
      end
      tick;
      n_vec++;
      if (abort !== 1'b0 || busy !== 1'b0 || frame_cnt !== exp_frames || n_commit != c0) begin
         n_miss++;
         $display("FAIL ovr_after: got a=%b busy=%b cnt=%0d commits=%0d want 0 0 %0d 0", abort,
                  busy, frame_cnt, n_commit - c0, exp_frames);
      end
      quick_frame;
      n_vec++;
      if (frame_cnt !== exp_frames || overrun !== 1'b1) begin
         n_miss++;
         $display("FAIL ovr_next_frame: got cnt=%0d ovr=%b want cnt=%0d ovr=1", frame_cnt,
                  overrun, exp_frames);
      end
      clr_overrun = 1'b1;
      tick;
      clr_overrun = 1'b0;
      n_vec++;
      if (overrun !== 1'b0) begin
         n_miss++; $display("FAIL ovr_clear: got %b want 0", overrun);
      end
   endtask

   task automatic test_simultaneous;
      int c0;
      c0 = n_commit;
      vblnk = 1'b1;
      tick;
      for (int i = 0; i < 3; i++) begin
         tick; task_done[i] = 1'b1; tick; task_done = '0;
      end
      tick;
      task_done[3] = 1'b1;
      vblnk = 1'b0;
      tick;
      task_done = '0;
      n_vec++;
      if (abort !== 1'b1 || commit !== 1'b0) begin
         n_miss++; $display("FAIL sim_done_vs_fall: got a=%b c=%b want a=1 c=0", abort, commit);
      end
      tick;
      n_vec++;
      if (frame_cnt !== exp_frames || n_commit != c0) begin
         n_miss++;
         $display("FAIL sim_no_commit: got cnt=%0d commits=%0d want cnt=%0d commits=0",
                  frame_cnt, n_commit - c0, exp_frames);
      end
      clr_overrun = 1'b1;
      tick;
      clr_overrun = 1'b0;
      vblnk = 1'b1;
      tick;
      tick;
      vblnk = 1'b0;
      clr_overrun = 1'b1;
      tick;
      clr_overrun = 1'b0;
      n_vec++;
      if (overrun !== 1'b1 || abort !== 1'b1) begin
         n_miss++; $display("FAIL sim_set_vs_clr: got ovr=%b a=%b want 1 1", overrun, abort);
      end
      tick;
      clr_overrun = 1'b1;
      tick;
      clr_overrun = 1'b0;
   endtask

   task automatic test_enable_ignored;
      enable = 1'b0;
      vblnk = 1'b1;
      tick;
      n_vec++;
      if (task_start !== '0 || busy !== 1'b0) begin
         n_miss++; $display("FAIL en_blocked: got st=%b busy=%b want 0 0", task_start, busy);
      end
      enable = 1'b1;
      repeat (3) tick;
      n_vec++;
      if (busy !== 1'b0) begin
         n_miss++; $display("FAIL en_no_catchup: got busy=%b want 0", busy);
      end
      vblnk = 1'b0;
      tick;
      vblnk = 1'b1;
      tick;
      tick;
      task_done = 4'b1110;
      tick;
      task_done = '0;
      n_vec++;
      if (task_active !== 4'b0001 || task_start !== '0) begin
         n_miss++;
         $display("FAIL ign_other_bits: got act=%b st=%b want act=0001 st=0", task_active,
                  task_start);
      end
      task_done = 4'b0001;
      tick;
      task_done = '0;
      n_vec++;
      if (task_start !== 4'b0010) begin
         n_miss++; $display("FAIL ign_then_start1: got %b want 0010", task_start);
      end
      enable = 1'b0;
      serve(1);
      n_vec++;
      if (commit !== 1'b1) begin
         n_miss++; $display("FAIL en_mid_sequence: got commit=%b want 1", commit);
      end
      tick;
      vblnk = 1'b0;
      tick;
      exp_frames = exp_frames + 1'b1;
      enable = 1'b1;
   endtask

   task automatic test_wrap;
      logic [FW-1:0] start_cnt;
      start_cnt = exp_frames;
      for (int f = 0; f < 16; f++) begin
         quick_frame;
         n_vec++;
         if (frame_cnt !== exp_frames) begin
            n_miss++; $display("FAIL wrap_frame%0d: got %0d want %0d", f, frame_cnt, exp_frames);
         end
      end
      n_vec++;
      if (frame_cnt !== start_cnt) begin
         n_miss++; $display("FAIL wrap_full_cycle: got %0d want %0d", frame_cnt, start_cnt);
      end
   endtask

   task automatic test_async_reset;
      vblnk = 1'b1;
      tick;
      tick;
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({task_start, task_active, commit, abort, busy, overrun, timeout_err, frame_cnt} !== '0)
      begin
         n_miss++;
         $display("FAIL async_reset: got act=%b busy=%b cnt=%0d ovr=%b, want all 0",
                  task_active, busy, frame_cnt, overrun);
      end
      exp_frames = '0;
      tick;
      rst = 1'b0;
      repeat (4) tick;
      n_vec++;
      if (busy !== 1'b0 || task_start !== '0) begin
         n_miss++;
         $display("FAIL release_in_blank: got busy=%b st=%b want 0 0", busy, task_start);
      end
      vblnk = 1'b0;
      tick;
      vblnk = 1'b1;
      tick;
      n_vec++;
      if (task_start !== 4'b0001) begin
         n_miss++; $display("FAIL next_rise_starts: got %b want 0001", task_start);
      end
      serve(0);
      tick;
      vblnk = 1'b0;
      tick;
      exp_frames = exp_frames + 1'b1;
      n_vec++;
      if (frame_cnt !== exp_frames) begin
         n_miss++; $display("FAIL post_reset_frame: got %0d want %0d", frame_cnt, exp_frames);
      end
   endtask

`ifdef VBS_TIMEOUT_EN
   task automatic test_timeout;
      int n;
      vblnk = 1'b1;
      tick;
      tick;
      task_done[0] = 1'b1;
      tick;
      task_done = '0;
      n = 0;
      while (abort !== 1'b1 && n < 40) begin
         tick;
         n++;
      end
      n_vec++;
      if (n != 16 || timeout_err !== 4'b0010 || overrun !== 1'b0) begin
         n_miss++;
         $display("FAIL timeout: got cycles=%0d to=%b ovr=%b want 16 0010 0", n, timeout_err,
                  overrun);
      end
      tick;
      vblnk = 1'b0;
      tick;
      clr_overrun = 1'b1;
      tick;
      clr_overrun = 1'b0;
      n_vec++;
      if (timeout_err !== '0) begin
         n_miss++; $display("FAIL timeout_clear: got %b want 0000", timeout_err);
      end
   endtask
`else
   task automatic test_timeout;
      vblnk = 1'b1;
      tick;
      tick;
      task_done[0] = 1'b1;
      tick;
      task_done = '0;
      repeat (40) tick;
      n_vec++;
      if (busy !== 1'b1 || task_active !== 4'b0010 || timeout_err !== '0 || abort !== 1'b0) begin
         n_miss++;
         $display("FAIL no_timeout: got busy=%b act=%b to=%b a=%b want 1 0010 0000 0", busy,
                  task_active, timeout_err, abort);
      end
      task_done[1] = 1'b1;
      tick;
      task_done = '0;
      serve(2);
      tick;
      vblnk = 1'b0;
      tick;
      exp_frames = exp_frames + 1'b1;
      n_vec++;
      if (frame_cnt !== exp_frames) begin
         n_miss++; $display("FAIL no_timeout_commit: got %0d want %0d", frame_cnt, exp_frames);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_nominal;
      test_overrun;
      test_simultaneous;
      test_enable_ignored;
      test_wrap;
      test_timeout;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
